rv_alu_r: RTL and testbench

//   RV32I R-type integer ALU for the execute stage.

---
 rtl/rv_alu_pkg.sv | 29 ++
 rtl/rv_alu_r_shifter.sv | 32 +++
 rtl/rv_alu_r.sv | 93 +++++++++
 tb/tb_rv_alu_r.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// RV32I R-type ALU shared definitions: opcode encodings and datapath width.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package rv_alu_pkg;

    localparam int XLEN = 32;

    // Operation code is {funct7[5], funct3}.
    localparam logic [3:0] OP_ADD  = 4'b0_000;
    localparam logic [3:0] OP_SUB  = 4'b1_000;
    localparam logic [3:0] OP_SLL  = 4'b0_001;
    localparam logic [3:0] OP_SLT  = 4'b0_010;
    localparam logic [3:0] OP_SLTU = 4'b0_011;
    localparam logic [3:0] OP_XOR  = 4'b0_100;
    localparam logic [3:0] OP_SRL  = 4'b0_101;
    localparam logic [3:0] OP_SRA  = 4'b1_101;
    localparam logic [3:0] OP_OR   = 4'b0_110;
    localparam logic [3:0] OP_AND  = 4'b0_111;

    // Bit reversal lets the right-shifting barrel also perform left shifts.
    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = d[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rv_alu_r_shifter.sv
// 5-stage barrel shifter shared by SLL, SRL and SRA.
// Latency: combinational, 0 cycles.
// Backpressure: none; output follows inputs.
// Ports: i_data (operand), i_shamt (shift amount), i_dir (1=left, 0=right),
//        i_arith (sign fill on right shifts), o_data (shifted result).
module rv_shifter
    import rv_alu_pkg::*;
(
    input  logic [XLEN-1:0] i_data,
    input  logic [4:0]      i_shamt,
    input  logic            i_dir,
    input  logic            i_arith,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_stage [0:5];
    logic            w_fill;

    // Left shifts run through the same right-shift barrel on reversed data,
    // so the fill bit must be zero for them regardless of i_arith.
    assign w_fill     = i_arith & ~i_dir & i_data[XLEN-1];
    assign w_stage[0] = i_dir ? bit_rev(i_data) : i_data;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign w_stage[k+1] = i_shamt[k] ? {{SH{w_fill}}, w_stage[k][XLEN-1:SH]}
                                         : w_stage[k];
    end

    assign o_data = i_dir ? bit_rev(w_stage[5]) : w_stage[5];

endmodule

// File: rtl/rv_alu_r.sv
// RV32I R-type integer ALU, rd = rs1 OP rs2 with OP = {funct7[5], funct3}.
// Latency: 1 cycle, result and valid registered; back-to-back ops every cycle.
// Backpressure: none, no ready; rd_out/illegal hold when valid_in is low.
// Ports: clk, rst_n (async active-low), valid_in, rs1_in, rs2_in, funct3,
//        funct7_r -> rd_out, valid_out, illegal.
module rv_alu_r
    import rv_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [2:0]      funct3,
    input  logic            funct7_r,
    output logic [XLEN-1:0] rd_out,
    output logic            valid_out,
    output logic            illegal
);

    logic [3:0]      w_funct;
    logic            w_sub;
    logic [XLEN-1:0] w_b;
    logic [XLEN:0]   w_sum;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_shl;
    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_result;
    logic            w_illegal;

    logic [XLEN-1:0] r_rd;
    logic            r_valid;
    logic            r_illegal;

    assign w_funct = {funct7_r, funct3};

    // One adder serves ADD, SUB and both compares: subtract is rs1 + ~rs2 + 1.
    assign w_sub = (w_funct == OP_SUB) || (w_funct == OP_SLT) || (w_funct == OP_SLTU);
    assign w_b   = w_sub ? ~rs2_in : rs2_in;
    assign w_sum = {1'b0, rs1_in} + {1'b0, w_b} + {{XLEN{1'b0}}, w_sub};

    // Carry-out of the subtract is "no borrow", i.e. rs1 >= rs2 unsigned.
    assign w_lt_u = ~w_sum[XLEN];
    // With differing signs the negative operand is smaller; otherwise the
    // difference cannot overflow and its sign bit decides.
    assign w_lt_s = (rs1_in[XLEN-1] != rs2_in[XLEN-1]) ? rs1_in[XLEN-1]
                                                       : w_sum[XLEN-1];

    assign w_shl = (funct3 == 3'b001);

    rv_shifter u_shifter (
        .i_data  (rs1_in),
        .i_shamt (rs2_in[4:0]),
        .i_dir   (w_shl),
        .i_arith (funct7_r),
        .o_data  (w_shift)
    );

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (w_funct)
            OP_ADD, OP_SUB:          w_result = w_sum[XLEN-1:0];
            OP_SLL, OP_SRL, OP_SRA:  w_result = w_shift;
            OP_SLT:                  w_result = {{(XLEN-1){1'b0}}, w_lt_s};
            OP_SLTU:                 w_result = {{(XLEN-1){1'b0}}, w_lt_u};
            OP_XOR:                  w_result = rs1_in ^ rs2_in;
            OP_OR:                   w_result = rs1_in | rs2_in;
            OP_AND:                  w_result = rs1_in & rs2_in;
            default:                 w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd      <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_rd      <= w_result;
                r_illegal <= w_illegal;
            end
        end
    end

    assign rd_out    = r_rd;
    assign valid_out = r_valid;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_rv_alu_r.sv
module tb_rv_alu_r;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] rs1_in;
    logic [31:0] rs2_in;
    logic [2:0]  funct3;
    logic        funct7_r;
    logic [31:0] rd_out;
    logic        valid_out;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    rv_alu_r dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .rs1_in    (rs1_in),
        .rs2_in    (rs2_in),
        .funct3    (funct3),
        .funct7_r  (funct7_r),
        .rd_out    (rd_out),
        .valid_out (valid_out),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op at the falling edge, then step just past the next rising edge.
    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid_in = 1'b1;
        funct7_r = f[3];
        funct3   = f[2:0];
        rs1_in   = a;
        rs2_in   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Independent behavioural reference for the random sweep.
    function automatic logic [32:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        r   = 32'h0;
        ill = 1'b0;
        case (f)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; rs1_in = '0; rs2_in = '0; funct3 = '0; funct7_r = 1'b0;
        #12;
        checks++;
        if ({rd_out, valid_out, illegal} !== 34'h0) begin
            errors++;
            $display("FAIL reset: rd=%h vld=%b ill=%b, required all 0", rd_out, valid_out, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rd_out, valid_out, illegal} !== 34'h0) begin
            errors++;
            $display("FAIL reset_release: rd=%h vld=%b ill=%b, required all 0", rd_out, valid_out, illegal);
        end
    endtask

    task automatic test_add();
        @(negedge clk); #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL add_pre_valid: vld=%b required 0", valid_out);
        end
        issue(4'b0000, 32'h7FFFFFFF, 32'h00000001);
        checks++;
        if (rd_out !== 32'h80000000 || valid_out !== 1'b1) begin
            errors++; $display("FAIL add_ovf: rd=%h vld=%b required 80000000/1", rd_out, valid_out);
        end
        idle();
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 1'b0 || rd_out !== 32'h80000000) begin
            errors++; $display("FAIL add_valid_drop: vld=%b rd=%h required 0/80000000", valid_out, rd_out);
        end
        issue(4'b0000, 32'hFFFFFFFF, 32'h00000001);
        checks++;
        if (rd_out !== 32'h00000000) begin
            errors++; $display("FAIL add_wrap: rd=%h required 00000000", rd_out);
        end
        idle();
    endtask

    task automatic test_sub_slt();
        issue(4'b1000, 32'h0, 32'h1);
        checks++;
        if (rd_out !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL sub: rd=%h required ffffffff", rd_out);
        end
        issue(4'b0010, 32'hFFFFFFFF, 32'h1);
        checks++;
        if (rd_out !== 32'h1) begin
            errors++; $display("FAIL slt_neg: rd=%h required 00000001", rd_out);
        end
        issue(4'b0011, 32'hFFFFFFFF, 32'h1);
        checks++;
        if (rd_out !== 32'h0) begin
            errors++; $display("FAIL sltu_big: rd=%h required 00000000", rd_out);
        end
        issue(4'b0010, 32'h12345678, 32'h12345678);
        checks++;
        if (rd_out !== 32'h0) begin
            errors++; $display("FAIL slt_eq: rd=%h required 00000000", rd_out);
        end
        issue(4'b0011, 32'h00000005, 32'h80000000);
        checks++;
        if (rd_out !== 32'h1) begin
            errors++; $display("FAIL sltu_lt: rd=%h required 00000001", rd_out);
        end
        idle();
    endtask

    task automatic test_shift();
        issue(4'b0101, 32'h80000000, 32'h21);
        checks++;
        if (rd_out !== 32'h40000000) begin
            errors++; $display("FAIL srl: rd=%h required 40000000", rd_out);
        end
        issue(4'b1101, 32'h80000000, 32'h21);
        checks++;
        if (rd_out !== 32'hC0000000) begin
            errors++; $display("FAIL sra: rd=%h required c0000000", rd_out);
        end
        issue(4'b0001, 32'h1, 32'h1F);
        checks++;
        if (rd_out !== 32'h80000000) begin
            errors++; $display("FAIL sll: rd=%h required 80000000", rd_out);
        end
        issue(4'b1101, 32'h8000_1234, 32'hFFFF_FFE0);
        checks++;
        if (rd_out !== 32'h8000_1234) begin
            errors++; $display("FAIL sra_zero: rd=%h required 80001234", rd_out);
        end
        idle();
    endtask

    task automatic test_logic();
        issue(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00);
        checks++;
        if (rd_out !== 32'h0FF00FF0) begin
            errors++; $display("FAIL xor: rd=%h required 0ff00ff0", rd_out);
        end
        issue(4'b0110, 32'hF0F0F0F0, 32'hFF00FF00);
        checks++;
        if (rd_out !== 32'hFFF0FFF0) begin
            errors++; $display("FAIL or: rd=%h required fff0fff0", rd_out);
        end
        issue(4'b0111, 32'hF0F0F0F0, 32'hFF00FF00);
        checks++;
        if (rd_out !== 32'hF000F000) begin
            errors++; $display("FAIL and: rd=%h required f000f000", rd_out);
        end
        idle();
    endtask

    task automatic test_illegal();
        issue(4'b1001, 32'h5, 32'h7);
        checks++;
        if (rd_out !== 32'h0 || illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_set: rd=%h ill=%b required 00000000/1", rd_out, illegal);
        end
        // Idle cycle with a legal code on the bus: illegal and rd_out must hold.
        @(negedge clk);
        valid_in = 1'b0; funct7_r = 1'b0; funct3 = 3'b000; rs1_in = 32'h9; rs2_in = 32'h9;
        @(posedge clk); #1;
        checks++;
        if (illegal !== 1'b1 || rd_out !== 32'h0 || valid_out !== 1'b0) begin
            errors++; $display("FAIL illegal_hold: rd=%h ill=%b vld=%b required 0/1/0", rd_out, illegal, valid_out);
        end
        issue(4'b0000, 32'h2, 32'h3);
        checks++;
        if (illegal !== 1'b0 || rd_out !== 32'h5) begin
            errors++; $display("FAIL illegal_clear: rd=%h ill=%b required 00000005/0", rd_out, illegal);
        end
        idle();
    endtask

    task automatic test_async_reset();
        issue(4'b0110, 32'hDEAD0000, 32'h0000BEEF);
        // Assert reset between edges with valid_in still high.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_out, valid_out, illegal} !== 34'h0) begin
            errors++; $display("FAIL async_reset: rd=%h vld=%b ill=%b required all 0", rd_out, valid_out, illegal);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back_sweep();
        logic [31:0] a, b;
        logic [32:0] exp;
        for (int f = 0; f < 16; f++) begin
            for (int n = 0; n < 5; n++) begin
                a = $urandom;
                b = $urandom;
                if (n == 0) b = a;
                exp = ref_alu(4'(f), a, b);
                issue(4'(f), a, b);
                checks++;
                if (rd_out !== exp[31:0] || illegal !== exp[32] || valid_out !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep f=%h a=%h b=%h: rd=%h ill=%b vld=%b required %h/%b/1",
                             f, a, b, rd_out, illegal, valid_out, exp[31:0], exp[32]);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_shift();
        test_logic();
        test_illegal();
        test_async_reset();
        test_back_to_back_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
